// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: FSM state
// encodings, major opcode constants, ALUop codes and ALU B-operand selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_IMM_EXEC  = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Main control FSM of the multi-cycle RV32I core. Sequences the shared
// datapath through fetch/decode/execute/memory/writeback steps, stalls on
// the memory ready handshake, counts retired instructions and halts on
// unsupported opcodes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            IR[6:0], stable from DECODE onward
//   zero              ALU zero flag (branch decision)
//   mem_ready         memory completes current transfer this cycle
//   pc_we, pc_src     PC load enable / source select
//   iord              memory address select (PC or ALUOut)
//   mem_rd, mem_wr    memory requests
//   ir_we             instruction register load
//   reg_we, mem_to_reg register file write enable / source
//   alu_src_a/b, alu_op ALU operand selects and op class
//   halted, state     status / debug
//   instret           retired instruction counter (wraps)
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 iord,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 halted,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_e                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle; it is only committed on
        // the ready edge so the request stays stable while stalled.
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut for a possible BRANCH.
        alu_src_b = SRCB_BOFF;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_ITYPE:          state_d = S_IMM_EXEC;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // ALU compares rs1 - rs2; the target already sits in ALUOut.
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_we     = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
  end

  assign halted  = (state_q == S_HALT);
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle RV32I core: sequences the shared datapath (PC, memory port, IR, register file, single ALU) over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It generates every datapath strobe and mux select, including the 2-bit ALUop consumed by the existing ALU control decoder. It stalls on a single-port memory ready handshake, counts retired instructions, and halts on unsupported opcodes.

## Interface
Parameters:
- INSTRET_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- opcode  input  7  IR[6:0]; stable from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current read/write this cycle
- pc_we  output  1  PC load enable
- pc_src  output  1  0 = ALU result, 1 = ALUOut register (branch target)
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request
- ir_we  output  1  IR load enable
- reg_we  output  1  register-file write enable
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = MDR
- alu_src_a  output  1  0 = PC, 1 = rs1 register
- alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = immediate, 11 = branch offset
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded
- halted  output  1  FSM in HALT
- state  output  4  current state (debug)
- instret  output  INSTRET_W  retired instruction count

## Operation
- Moore outputs are decoded from the state register. Exception: `pc_we` in BRANCH and the `mem_ready` gating of `ir_we`/`pc_we` in FETCH. Any output not listed for a state is 0.
- FETCH (0): mem_rd=1, iord=0, src_a=0, src_b=01, alu_op=00. If mem_ready: ir_we=1, pc_we=1, pc_src=0, go to DECODE. Otherwise hold.
- DECODE (1): src_a=0, src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 (load) or 0100011 (store) -> MEM_ADDR
  - 0110011 -> EXECUTE
  - 0010011 -> IMM_EXEC
  - 1100011 -> BRANCH
  - any other -> HALT
- MEM_ADDR (2): src_a=1, src_b=10, alu_op=00. Next: MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ (3): mem_rd=1, iord=1. Go to MEM_WB when mem_ready.
- MEM_WB (4): reg_we=1, mem_to_reg=1. Go to FETCH; retire.
- MEM_WRITE (5): mem_wr=1, iord=1. When mem_ready: go to FETCH; retire.
- EXECUTE (6): src_a=1, src_b=00, alu_op=10. Go to ALU_WB.
- IMM_EXEC (7): src_a=1, src_b=10, alu_op=00. Go to ALU_WB.
- ALU_WB (8): reg_we=1, mem_to_reg=0. Go to FETCH; retire.
- BRANCH (9): src_a=1, src_b=00, alu_op=01, pc_src=1, pc_we=zero. Go to FETCH; retire.
- HALT (10): halted=1, all strobes 0. Exit only via reset.
- Encodings 11–15 are unreachable; if entered, go to HALT.
- Retire: instret increments by 1 on the clock edge leaving MEM_WB, MEM_WRITE (ready), ALU_WB, or BRANCH. Wraps from all-ones to 0.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, instret=0, halted=0. Outputs immediately take FETCH values: mem_rd=1, iord=0, src_a=0, src_b=01, alu_op=00, all other outputs 0.
- Reset deassertion is synchronised by the integrator; the first active edge follows release.
- Memory handshake:
  - mem_rd/mem_wr and iord stay asserted and stable every cycle until an edge samples mem_ready=1.
  - Exactly one transfer completes per request.
  - mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
  - ir_we/pc_we pulse exactly one cycle per fetch.
- Latency with zero-wait memory: R-type/I-ALU 4 cycles, load 5, store 4, branch 3. Each wait cycle adds 1.
- Reset mid-instruction abandons it with no retire. An in-flight mem_wr drops immediately.
- Throughput: no overlap; the next FETCH begins the cycle after the retiring state.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - state encodings
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH)
  - ALUop codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - alu_src_b select codes
- No sub-module is required: a state register, next-state logic, an output decoder and the instret counter all sit in one module.

## Test plan
- R-type (opcode 0110011), mem_ready tied 1 -> states 0,1,6,8,0. alu_op=10 in EXECUTE only. reg_we high one cycle. instret 0->1 after 4 cycles.
- Load with mem_ready low 3 cycles in FETCH and 2 in MEM_READ -> 10 cycles total. mem_rd held high through all wait cycles. ir_we high only on the ready cycle. mem_to_reg=1 with reg_we in MEM_WB.
- Branch 1100011 with zero=1 -> pc_we=1, pc_src=1 in BRANCH. Repeat with zero=0 -> pc_we=0. Each takes 3 cycles; instret +1 each.
- Opcode 1111111 -> HALT after DECODE. halted=1 and all strobes 0 for 20 cycles; instret unchanged. Pulse rst_n -> FETCH, halted=0.
- Store, assert rst_n low mid-cycle in MEM_WRITE with mem_ready=0 -> state=0 and mem_wr=0 before the next edge. instret=0, no retire.
